id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high; sampled on rising edge of clk only.
REQ-003 SHALL have port: ID_Ctrl  in  16  decoded control bundle from decoder: [1:0] PCSrc, [2] Branch, [3] RegWrite, [5:4] RegDst, [6] MemRead, [7] MemWrite, [8] ExWrite, [10:9] ExAno, [12:11] MemtoReg, [13] ALUSrc1, [14] ALUSrc2, [15] LuOp.
REQ-004 SHALL have port: ID_Valid  in  1  IF/ID holds a real instruction.
REQ-005 SHALL have port: ID_PC4  in  32  PC+4 of ID instruction.
REQ-006 SHALL have port: ID_RsData  in  32  register-file rs read data.
REQ-007 SHALL have port: ID_RtData  in  32  register-file rt read data.
REQ-008 SHALL have port: ID_Imm  in  32  extended immediate.
REQ-009 SHALL have port: ID_Rs, ID_Rt, ID_Rd, ID_Shamt  in  5 each  instruction fields.
REQ-010 SHALL have port: ID_Funct  in  6  funct field.
REQ-011 SHALL have port: EX_BranchTaken  in  1  branch/jump resolved taken in EX; flush request.
REQ-012 SHALL have ports: EX_Ctrl (16), EX_Valid (1), EX_PC4, EX_RsData, EX_RtData, EX_Imm (32 each), EX_Rs, EX_Rt, EX_Rd, EX_Shamt (5 each), EX_Funct (6)  out  registered copies of the ID_ counterparts.
REQ-013 SHALL have port: Stall  out  1  combinational load-use stall to PC and IF/ID (hold).
REQ-014 SHALL have port: BubbleCount  out  16  count of load-use bubbles inserted.

Function
REQ-015 SHALL define UsesRs = ~ID_Ctrl[13] & (ID_Ctrl[1:0] != 2'b10).
REQ-016 SHALL define UsesRt = ~ID_Ctrl[14] | ID_Ctrl[7] | ID_Ctrl[2].
REQ-017 SHALL drive Stall = EX_Valid & EX_Ctrl[6] & (EX_Rt != 0) & ID_Valid & ~EX_BranchTaken & ((UsesRs & EX_Rt==ID_Rs) | (UsesRt & EX_Rt==ID_Rt)).
REQ-018 SHALL define a bubble as all EX_ outputs, including EX_Valid, equal to zero.
REQ-019 SHALL apply per-edge priority: reset > EX_BranchTaken (load bubble) > Stall (load bubble) > normal (load all ID_ inputs into EX_ registers).
REQ-020 SHALL have one-cycle latency: ID_ values present at edge N appear on EX_ outputs after edge N and hold until next edge.
REQ-021 SHALL load a bubble in place of the ID instruction when ID_Valid=0 (ID_Ctrl ignored).
REQ-022 SHALL increment BubbleCount by 1 only on edges where Stall=1 and reset=0; saturate at 16'hFFFF, no wrap.
REQ-023 SHALL not increment BubbleCount on flush-induced bubbles.
REQ-024 SHALL guarantee a stall lasts exactly one cycle: after the bubble, EX_Valid=0 and Stall deasserts; instruction in ID (held upstream) loads on following edge.
REQ-025 SHALL have no dependence of Stall on ID_ data buses or EX_ data buses.

Reset
REQ-026 SHALL, on an edge with reset=1, clear all EX_ outputs to 0 and BubbleCount to 0, overriding all other inputs.
REQ-027 SHALL produce Stall=0 in the cycle after reset (EX_Valid=0).
REQ-028 SHALL abandon a pending stall if reset asserts during it; counter does not count that edge.

Verification
REQ-029 Reset: reset=1 one edge with arbitrary inputs -> all EX_ outputs 0, BubbleCount=0, Stall=0.
REQ-030 Pass-through: ID_Valid=1, add $3,$1,$2 (ID_Ctrl=16'h0008, Rs=1, Rt=2, Rd=3, RsData=5, RtData=7) -> next cycle EX_Ctrl=16'h0008, EX_RsData=5, EX_RtData=7, EX_Rd=3, EX_Valid=1.
REQ-031 Load-use: lw $8 (EX_Ctrl[6]=1, EX_Rt=8) in EX, add using rs=8 in ID -> Stall=1 one cycle, bubble in EX, BubbleCount 0->1, add enters EX on next edge with Stall=0.
REQ-032 $0 load: lw to rt=0 followed by use of $0 -> Stall=0, no bubble, BubbleCount unchanged.
REQ-033 Flush priority: load-use hazard and EX_BranchTaken=1 same cycle -> Stall=0, bubble loaded, BubbleCount unchanged.
REQ-034 Saturation: preload BubbleCount to 16'hFFFF via repeated hazards, one more hazard -> BubbleCount stays 16'hFFFF; reset during Stall=1 -> EX_ zero, BubbleCount 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush handling and a
// saturating counter of inserted load-use bubbles.
module id_ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ID_Ctrl,
    input  logic        ID_Valid,
    input  logic [31:0] ID_PC4,
    input  logic [31:0] ID_RsData,
    input  logic [31:0] ID_RtData,
    input  logic [31:0] ID_Imm,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic [4:0]  ID_Rd,
    input  logic [4:0]  ID_Shamt,
    input  logic [5:0]  ID_Funct,
    input  logic        EX_BranchTaken,
    output logic [15:0] EX_Ctrl,
    output logic        EX_Valid,
    output logic [31:0] EX_PC4,
    output logic [31:0] EX_RsData,
    output logic [31:0] EX_RtData,
    output logic [31:0] EX_Imm,
    output logic [4:0]  EX_Rs,
    output logic [4:0]  EX_Rt,
    output logic [4:0]  EX_Rd,
    output logic [4:0]  EX_Shamt,
    output logic [5:0]  EX_Funct,
    output logic        Stall,
    output logic [15:0] BubbleCount
);
    localparam int DATA_W = 32;

    logic [15:0]       ctrl_p1;
    logic              vld_p1;
    logic [DATA_W-1:0] pc4_p1, rsData_p1, rtData_p1, imm_p1;
    logic [4:0]        rs_p1, rt_p1, rd_p1, shamt_p1;
    logic [5:0]        funct_p1;
    logic [15:0]       bubbleCount;

    logic usesRs, usesRt, rsHazard, rtHazard, loadBubble;

    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Hazard detection looks only at register indices and control bits.
    always_comb begin
        usesRs     = ~ID_Ctrl[13] & (ID_Ctrl[1:0] != 2'b10);
        usesRt     = ~ID_Ctrl[14] | ID_Ctrl[7] | ID_Ctrl[2];
        rsHazard   = usesRs & (rt_p1 == ID_Rs);
        rtHazard   = usesRt & (rt_p1 == ID_Rt);
        Stall      = vld_p1 & ctrl_p1[6] & (rt_p1 != 5'd0) & ID_Valid & ~EX_BranchTaken
                   & (rsHazard | rtHazard);
        loadBubble = EX_BranchTaken | Stall | ~ID_Valid;
    end

    // ID -> EX stage boundary
    always_ff @(posedge clk) begin
        if (reset || loadBubble) begin
            ctrl_p1   <= '0;
            vld_p1    <= 1'b0;
            pc4_p1    <= '0;
            rsData_p1 <= '0;
            rtData_p1 <= '0;
            imm_p1    <= '0;
            rs_p1     <= '0;
            rt_p1     <= '0;
            rd_p1     <= '0;
            shamt_p1  <= '0;
            funct_p1  <= '0;
        end else begin
            ctrl_p1   <= ID_Ctrl;
            vld_p1    <= 1'b1;
            pc4_p1    <= ID_PC4;
            rsData_p1 <= ID_RsData;
            rtData_p1 <= ID_RtData;
            imm_p1    <= ID_Imm;
            rs_p1     <= ID_Rs;
            rt_p1     <= ID_Rt;
            rd_p1     <= ID_Rd;
            shamt_p1  <= ID_Shamt;
            funct_p1  <= ID_Funct;
        end
    end

    // Flush bubbles never count because Stall is already masked by EX_BranchTaken.
    always_ff @(posedge clk) begin
        if (reset)
            bubbleCount <= '0;
        else if (Stall)
            bubbleCount <= satInc(bubbleCount);
        else
            bubbleCount <= bubbleCount;
    end

    assign EX_Ctrl     = ctrl_p1;
    assign EX_Valid    = vld_p1;
    assign EX_PC4      = pc4_p1;
    assign EX_RsData   = rsData_p1;
    assign EX_RtData   = rtData_p1;
    assign EX_Imm      = imm_p1;
    assign EX_Rs       = rs_p1;
    assign EX_Rt       = rt_p1;
    assign EX_Rd       = rd_p1;
    assign EX_Shamt    = shamt_p1;
    assign EX_Funct    = funct_p1;
    assign BubbleCount = bubbleCount;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a reference model pushes the expected EX
// contents and bubble count per edge; they are popped and compared after the edge.
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ID_Ctrl;
    logic        ID_Valid;
    logic [31:0] ID_PC4, ID_RsData, ID_RtData, ID_Imm;
    logic [4:0]  ID_Rs, ID_Rt, ID_Rd, ID_Shamt;
    logic [5:0]  ID_Funct;
    logic        EX_BranchTaken;
    logic [15:0] EX_Ctrl;
    logic        EX_Valid;
    logic [31:0] EX_PC4, EX_RsData, EX_RtData, EX_Imm;
    logic [4:0]  EX_Rs, EX_Rt, EX_Rd, EX_Shamt;
    logic [5:0]  EX_Funct;
    logic        Stall;
    logic [15:0] BubbleCount;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .ID_Ctrl(ID_Ctrl), .ID_Valid(ID_Valid),
        .ID_PC4(ID_PC4), .ID_RsData(ID_RsData), .ID_RtData(ID_RtData), .ID_Imm(ID_Imm),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .ID_Shamt(ID_Shamt),
        .ID_Funct(ID_Funct), .EX_BranchTaken(EX_BranchTaken),
        .EX_Ctrl(EX_Ctrl), .EX_Valid(EX_Valid), .EX_PC4(EX_PC4),
        .EX_RsData(EX_RsData), .EX_RtData(EX_RtData), .EX_Imm(EX_Imm),
        .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd), .EX_Shamt(EX_Shamt),
        .EX_Funct(EX_Funct), .Stall(Stall), .BubbleCount(BubbleCount)
    );

    typedef struct packed {
        logic [15:0] ctrl;
        logic        valid;
        logic [31:0] pc4, rsData, rtData, imm;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  funct;
    } exRec_t;

    exRec_t      mEx = '0;
    logic [15:0] mCount = '0;
    exRec_t      expQ[$];
    logic [15:0] cntQ[$];
    int          checks = 0;
    int          errors = 0;

    function automatic exRec_t idRec();
        return '{ctrl: ID_Ctrl, valid: 1'b1, pc4: ID_PC4, rsData: ID_RsData,
                 rtData: ID_RtData, imm: ID_Imm, rs: ID_Rs, rt: ID_Rt, rd: ID_Rd,
                 shamt: ID_Shamt, funct: ID_Funct};
    endfunction

    function automatic exRec_t dutRec();
        return '{ctrl: EX_Ctrl, valid: EX_Valid, pc4: EX_PC4, rsData: EX_RsData,
                 rtData: EX_RtData, imm: EX_Imm, rs: EX_Rs, rt: EX_Rt, rd: EX_Rd,
                 shamt: EX_Shamt, funct: EX_Funct};
    endfunction

    function automatic logic modelStall();
        logic uRs, uRt;
        uRs = !ID_Ctrl[13] && (ID_Ctrl[1:0] != 2'b10);
        uRt = !ID_Ctrl[14] || ID_Ctrl[7] || ID_Ctrl[2];
        return mEx.valid && mEx.ctrl[6] && (mEx.rt != 5'd0) && ID_Valid && !EX_BranchTaken
            && ((uRs && mEx.rt == ID_Rs) || (uRt && mEx.rt == ID_Rt));
    endfunction

    task automatic setIns(input logic v, input logic [15:0] c, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rsd, input logic [31:0] rtd);
        reset          = 1'b0;
        EX_BranchTaken = 1'b0;
        ID_Valid       = v;
        ID_Ctrl        = c;
        ID_Rs          = rs;
        ID_Rt          = rt;
        ID_Rd          = rd;
        ID_RsData      = rsd;
        ID_RtData      = rtd;
        ID_PC4         = $urandom;
        ID_Imm         = $urandom;
        ID_Shamt       = 5'($urandom);
        ID_Funct       = 6'($urandom);
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step(input string tag);
        logic        expStall;
        exRec_t      e;
        logic [15:0] c;
        #1;
        expStall = modelStall();
        checks++;
        assert (Stall === expStall) else begin
            errors++;
            $error("FAIL %s.stall observed=%0b expected=%0b", tag, Stall, expStall);
        end
        if (reset) begin
            mEx    = '0;
            mCount = '0;
        end else begin
            if (expStall && mCount != 16'hFFFF) mCount = mCount + 16'd1;
            if (EX_BranchTaken || expStall || !ID_Valid) mEx = '0;
            else mEx = idRec();
        end
        expQ.push_back(mEx);
        cntQ.push_back(mCount);
        @(posedge clk);
        #1;
        e = expQ.pop_front();
        c = cntQ.pop_front();
        checks++;
        assert (dutRec() === e) else begin
            errors++;
            $error("FAIL %s.ex observed=%h expected=%h", tag, dutRec(), e);
        end
        checks++;
        assert (BubbleCount === c) else begin
            errors++;
            $error("FAIL %s.count observed=%h expected=%h", tag, BubbleCount, c);
        end
        @(negedge clk);
    endtask

    initial begin
        setIns(1'b1, 16'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom);
        reset          = 1'b1;
        EX_BranchTaken = 1'($urandom);
        @(negedge clk);
        step("reset");

        setIns(1'b1, 16'h0008, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
        step("add_pass");

        setIns(1'b1, 16'h4848, 5'd1, 5'd8, 5'd0, 32'd100, 32'd200);
        step("lw8");
        setIns(1'b1, 16'h0008, 5'd8, 5'd2, 5'd9, 32'd11, 32'd22);
        step("lu_stall");
        step("lu_release");

        setIns(1'b1, 16'h4848, 5'd1, 5'd0, 5'd0, 32'd1, 32'd2);
        step("lw0");
        setIns(1'b1, 16'h0008, 5'd0, 5'd0, 5'd9, 32'd3, 32'd4);
        step("use0");

        setIns(1'b1, 16'h4848, 5'd1, 5'd8, 5'd0, 32'd1, 32'd2);
        step("lw8_f");
        setIns(1'b1, 16'h0008, 5'd8, 5'd2, 5'd9, 32'd3, 32'd4);
        EX_BranchTaken = 1'b1;
        step("flush");

        setIns(1'b1, 16'h4848, 5'd1, 5'd8, 5'd0, 32'd1, 32'd2);
        step("lw8_s");
        setIns(1'b1, 16'h4080, 5'd2, 5'd8, 5'd0, 32'd3, 32'd4);
        step("sw_rt_stall");
        step("sw_release");

        setIns(1'b1, 16'h4848, 5'd1, 5'd8, 5'd0, 32'd1, 32'd2);
        step("lw8_sh");
        setIns(1'b1, 16'h6008, 5'd8, 5'd8, 5'd4, 32'd3, 32'd4);
        step("shift_nostall");

        setIns(1'b1, 16'h4848, 5'd1, 5'd8, 5'd0, 32'd1, 32'd2);
        step("lw8_jr");
        setIns(1'b1, 16'h4002, 5'd8, 5'd8, 5'd0, 32'd3, 32'd4);
        step("jr_nostall");

        setIns(1'b1, 16'h4848, 5'd1, 5'd8, 5'd0, 32'd1, 32'd2);
        step("lw8_br");
        setIns(1'b1, 16'h4004, 5'd3, 5'd8, 5'd0, 32'd3, 32'd4);
        step("beq_rt_stall");
        step("beq_release");

        setIns(1'b0, 16'hFFFF, 5'd8, 5'd8, 5'd8, 32'd9, 32'd9);
        step("invalid");

        force dut.bubbleCount = 16'hFFFE;
        mCount = 16'hFFFE;
        setIns(1'b0, 16'h0000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
        step("preload");
        release dut.bubbleCount;

        setIns(1'b1, 16'h4848, 5'd1, 5'd8, 5'd0, 32'd1, 32'd2);
        step("lw8_sat1");
        setIns(1'b1, 16'h0008, 5'd8, 5'd2, 5'd9, 32'd3, 32'd4);
        step("sat_reach");
        step("sat_release1");
        setIns(1'b1, 16'h4848, 5'd1, 5'd8, 5'd0, 32'd1, 32'd2);
        step("lw8_sat2");
        setIns(1'b1, 16'h0008, 5'd8, 5'd2, 5'd9, 32'd3, 32'd4);
        step("sat_hold");
        step("sat_release2");

        setIns(1'b1, 16'h4848, 5'd1, 5'd8, 5'd0, 32'd1, 32'd2);
        step("lw8_rst");
        setIns(1'b1, 16'h0008, 5'd8, 5'd2, 5'd9, 32'd3, 32'd4);
        reset = 1'b1;
        step("reset_in_stall");
        reset = 1'b0;
        step("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
